// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one memory port.
// Build option: CACHE_ARBITER_ROUND_ROBIN_EN selects round-robin on collisions.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   d_req;
    logic   grant_d;

    assign d_req = d_read | d_write;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    // last_d_q set means the data cache held the most recent grant
    logic last_d_q, last_d_d;

    // On a collision, favour the side that did not win last time
    always_comb begin
        grant_d = d_req & (~i_read | ~last_d_q);
    end

    // Remember which side was granted when leaving IDLE
    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE) begin
            if (grant_d) begin
                last_d_d = 1'b1;
            end else if (i_read) begin
                last_d_d = 1'b0;
            end
        end
    end

    // Last-grant register, cleared to the instruction side
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    // Fixed priority: a pending data request always wins
    always_comb begin
        grant_d = d_req;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant from IDLE, return to IDLE after each completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = SERVE_D;
                end else if (i_read) begin
                    state_d = SERVE_I;
                end
            end
            SERVE_I: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: route the served side, everything quiet in IDLE or reset
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        if (rst) begin
            unique case (state_q)
                SERVE_I: begin
                    mem_read = 1'b1;
                    mem_addr = i_addr;
                    i_resp   = mem_resp;
                end
                SERVE_D: begin
                    mem_read  = d_read & ~d_write;
                    mem_write = d_write;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    d_resp    = mem_resp;
                end
                default: begin
                    mem_read = 1'b0;
                end
            endcase
        end
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed scenarios then random traffic.
// Expected responses are queued when requests are raised.
module tb_cache_arbiter;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    exp_t iq[$];
    exp_t dq[$];

    int n_cmp = 0;
    int n_err = 0;

    logic         ovr_en;
    logic [255:0] ovr;
    logic         rnd;
    logic         i_busy, d_busy, i_done, d_done;
    logic         mb_busy;
    int           mb_cnt;

    cache_arbiter #(
        .ADDR_W(32),
        .LINE_W(256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_resp   (i_resp),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_resp   (d_resp),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [255:0] fdat(input logic [31:0] a);
        return {8{a ^ 32'h9E3779B9}};
    endfunction

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic edge_t();
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
    endtask

    task automatic resp_now();
        mem_resp  = 1'b1;
        mem_rdata = ovr_en ? ovr : fdat(mem_addr);
    endtask

    task automatic sample_cycle();
        exp_t e;
        check("resp_onehot", i_resp & d_resp, 0);
        check("rw_excl", mem_read & mem_write, 0);
        if (i_resp) begin
            if (iq.size() == 0) begin
                check("i_resp_extra", 1, 0);
            end else begin
                e = iq.pop_front();
                check("i_addr", mem_addr, e.addr);
                check("i_kind", mem_read, 1);
                check("i_rdata", i_rdata, e.rdata);
            end
            i_done = 1'b1;
        end
        if (d_resp) begin
            if (dq.size() == 0) begin
                check("d_resp_extra", 1, 0);
            end else begin
                e = dq.pop_front();
                check("d_addr", mem_addr, e.addr);
                if (e.wr) begin
                    check("d_wr", mem_write, 1);
                    check("d_wdata", mem_wdata, e.wdata);
                end else begin
                    check("d_rd", mem_read, 1);
                    check("d_rdata", d_rdata, e.rdata);
                end
            end
            d_done = 1'b1;
        end
        if (rnd && (mem_read | mem_write) && !mb_busy && !mem_resp) begin
            mb_busy = 1'b1;
            mb_cnt  = $urandom_range(20, 1);
        end
    endtask

    task automatic settle();
        #1;
        sample_cycle();
    endtask

    task automatic rnd_cycle(input bit gen);
        logic [31:0] a;
        int          k;
        edge_t();
        if (i_done) begin
            i_read = 1'b0;
            i_busy = 1'b0;
            i_done = 1'b0;
        end
        if (d_done) begin
            d_read  = 1'b0;
            d_write = 1'b0;
            d_busy  = 1'b0;
            d_done  = 1'b0;
        end
        if (gen && !i_busy && $urandom_range(3) == 0) begin
            a      = $urandom & 32'hFFFFFFE0;
            i_read = 1'b1;
            i_addr = a;
            iq.push_back('{1'b0, a, 256'd0, fdat(a)});
            i_busy = 1'b1;
        end
        if (gen && !d_busy && $urandom_range(3) == 0) begin
            a       = $urandom & 32'hFFFFFFE0;
            k       = $urandom_range(7);
            d_addr  = a;
            d_wdata = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
            d_write = (k >= 5);
            d_read  = (k != 5 && k != 6);
            dq.push_back('{d_write, a, d_wdata, fdat(a)});
            d_busy = 1'b1;
        end
        if (mb_busy) begin
            mb_cnt--;
            if (mb_cnt == 0) begin
                mb_busy = 1'b0;
                resp_now();
            end
        end
        settle();
    endtask

    initial begin
        int guard;
        rst = 1'b0; i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        ovr_en = 1'b0; ovr = '0; rnd = 1'b0;
        i_busy = 0; d_busy = 0; i_done = 0; d_done = 0;
        mb_busy = 0; mb_cnt = 0;

        edge_t(); settle();
        edge_t(); settle();
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_i_resp", i_resp, 0);
        check("rst_d_resp", d_resp, 0);

        // instruction fill
        edge_t(); rst = 1'b1; settle();
        edge_t(); i_read = 1'b1; i_addr = 32'h60;
        iq.push_back('{1'b0, 32'h60, 256'd0, {32{8'hAB}}});
        settle();
        check("t1_idle_at_n", mem_read, 0);
        edge_t(); settle();
        check("t1_read_n1", mem_read, 1);
        check("t1_nowrite", mem_write, 0);
        check("t1_addr", mem_addr, 32'h60);
        check("t1_wdata", mem_wdata, 0);
        edge_t(); settle();
        edge_t(); ovr_en = 1'b1; ovr = {32{8'hAB}}; resp_now(); settle();
        check("t1_i_resp", i_resp, 1);
        check("t1_d_resp", d_resp, 0);
        ovr_en = 1'b0;
        edge_t(); i_read = 1'b0; settle();
        check("t1_resp_pulse", i_resp, 0);
        check("t1_back_idle", mem_read, 0);

        // data writeback
        edge_t(); d_write = 1'b1; d_addr = 32'h1000; d_wdata = {32{8'h5A}};
        dq.push_back('{1'b1, 32'h1000, {32{8'h5A}}, 256'd0});
        settle();
        check("t2_idle_at_n", mem_write, 0);
        edge_t(); settle();
        check("t2_write", mem_write, 1);
        check("t2_noread", mem_read, 0);
        check("t2_addr", mem_addr, 32'h1000);
        check("t2_wdata", mem_wdata, {32{8'h5A}});
        edge_t(); resp_now(); settle();
        check("t2_d_resp", d_resp, 1);
        check("t2_i_resp", i_resp, 0);
        edge_t(); d_write = 1'b0; settle();
        check("t2_gap_idle", mem_write, 0);

        // collisions from reset
        edge_t(); rst = 1'b0;
        i_read = 1'b1; i_addr = 32'h200;
        d_read = 1'b1; d_addr = 32'h300;
        iq.push_back('{1'b0, 32'h200, 256'd0, fdat(32'h200)});
        dq.push_back('{1'b0, 32'h300, 256'd0, fdat(32'h300)});
        settle();
        edge_t(); rst = 1'b1; settle();
        check("t3_idle_after_rst", mem_read, 0);
        edge_t(); settle();
        check("t3_first_is_d", mem_addr, 32'h300);
        check("t3_first_read", mem_read, 1);
        edge_t(); resp_now(); settle();
        check("t3_first_d_resp", d_resp, 1);
        edge_t(); d_addr = 32'h400;
        dq.push_back('{1'b0, 32'h400, 256'd0, fdat(32'h400)});
        settle();
        check("t3_gap", mem_read, 0);
        edge_t(); settle();
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
        check("t3_second_grant", mem_addr, 32'h200);
`else
        check("t3_second_grant", mem_addr, 32'h400);
`endif
        edge_t(); resp_now(); settle();
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
        edge_t(); i_read = 1'b0; settle();
        edge_t(); settle();
        check("t3_third_grant", mem_addr, 32'h400);
`else
        edge_t(); d_read = 1'b0; settle();
        edge_t(); settle();
        check("t3_third_grant", mem_addr, 32'h200);
`endif
        edge_t(); resp_now(); settle();
        edge_t(); i_read = 1'b0; d_read = 1'b0; settle();

        // illegal read+write: write wins
        edge_t(); d_read = 1'b1; d_write = 1'b1; d_addr = 32'h500;
        d_wdata = {8{32'hC3A5_0F1E}};
        dq.push_back('{1'b1, 32'h500, {8{32'hC3A5_0F1E}}, 256'd0});
        settle();
        edge_t(); settle();
        check("t4_write", mem_write, 1);
        check("t4_noread", mem_read, 0);
        edge_t(); resp_now(); settle();
        edge_t(); d_read = 1'b0; d_write = 1'b0; settle();

        // reset mid-transaction, then a late response
        edge_t(); d_read = 1'b1; d_addr = 32'h600; settle();
        edge_t(); settle();
        check("t5_serving", mem_read, 1);
        edge_t(); rst = 1'b0; settle();
        edge_t(); rst = 1'b1; d_read = 1'b0; resp_now(); settle();
        check("t5_mem_read", mem_read, 0);
        check("t5_mem_write", mem_write, 0);
        check("t5_mem_addr", mem_addr, 0);
        check("t5_mem_wdata", mem_wdata, 0);
        check("t5_i_resp", i_resp, 0);
        check("t5_d_resp", d_resp, 0);
        edge_t(); settle();
        check("t5_still_idle", mem_read, 0);
        check("t5_q_clean", iq.size() + dq.size(), 0);

        // random traffic
        rnd = 1'b1;
        i_busy = 0; d_busy = 0; i_done = 0; d_done = 0; mb_busy = 0;
        for (int c = 0; c < 10000; c++) begin
            rnd_cycle(1'b1);
        end
        guard = 0;
        while ((i_busy || d_busy || i_done || d_done) && guard < 1000) begin
            rnd_cycle(1'b0);
            guard++;
        end
        check("drain_timeout", guard >= 1000, 0);
        check("i_all_done", iq.size(), 0);
        check("d_all_done", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
